icache_fetch_tracker: RTL and testbench

Parametrised fetch-side interface between the IF stage and the instruction cache. It supports up to `MAX_OUT` outstanding line reads and buffers returned data in an in-order response FIFO with IF-side back-pressure. On flush it cancels in-flight requests by discarding their late responses. It replaces the single-outstanding fetch handshake and sits directly between IF and icache.

---
 rtl/icache_fetch_tracker_if.sv | 33 +++
 rtl/icache_fetch_tracker.sv | 137 +++++++++++++
 tb/tb_icache_fetch_tracker.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_tracker_if.sv
// Fetch-side bundle between IF, the fetch tracker and the instruction cache.
// The tracker takes the slave view; the IF stage and icache models take the master view.
interface icache_fetch_tracker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              flush_i;
  logic [ADDR_W-1:0] pc_i;
  logic              read_req_i;
  logic              req_ready_o;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic              read_done_o;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic [DATA_W-1:0] data_i;
  logic              data_valid_i;
  logic              data_ready_o;

  modport slave (
    input  flush_i, pc_i, read_req_i, resp_ready_i, addr_ready_i, data_i, data_valid_i,
    output req_ready_o, resp_data_o, resp_valid_o, read_done_o, addr_o, addr_valid_o,
           data_ready_o
  );

  modport master (
    output flush_i, pc_i, read_req_i, resp_ready_i, addr_ready_i, data_i, data_valid_i,
    input  req_ready_o, resp_data_o, resp_valid_o, read_done_o, addr_o, addr_valid_o,
           data_ready_o
  );
endinterface

// File: rtl/icache_fetch_tracker.sv
// Multi-outstanding fetch tracker: credit-limited request issue with a one-entry skid,
// in-order response FIFO, and flush-time cancellation by discarding stale cache beats.
module icache_fetch_tracker #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = XLEN,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  icache_fetch_tracker_if.slave bus
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]   LIMIT    = (CW + 1)'(MAX_OUT);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);

  logic              skid_valid_reg, skid_valid_next;
  logic [ADDR_W-1:0] skid_addr_reg, skid_addr_next;
  logic [CW-1:0]     in_flight_reg, in_flight_next;
  logic [CW-1:0]     discard_reg, discard_next;
  logic [CW-1:0]     occ_reg, occ_next;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [DATA_W-1:0] fifo_mem [MAX_OUT];

  logic [CW:0]   credit_used;
  logic [CW+1:0] credit_total;
  logic          req_ready;
  logic          accept;
  logic          addr_valid;
  logic          addr_hs;
  logic          data_ready;
  logic          data_hs;
  logic          drop;
  logic          push;
  logic          resp_valid;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode. addr_valid is gated by reset so a request held high
  // while the tracker is in reset never reaches the cache.
  always_comb begin
    credit_used = {1'b0, in_flight_reg} + {1'b0, occ_reg};
    req_ready   = ~bus.flush_i & ~skid_valid_reg & (credit_used < LIMIT);
    accept      = bus.read_req_i & req_ready;
    addr_valid  = ~rst_i & ~bus.flush_i & (skid_valid_reg | accept);
    addr_hs     = addr_valid & bus.addr_ready_i;
    data_ready  = (in_flight_reg != '0);
    data_hs     = bus.data_valid_i & data_ready;
    drop        = data_hs & (bus.flush_i | (discard_reg != '0));
    push        = data_hs & ~drop;
    resp_valid  = ~bus.flush_i & (occ_reg != '0);
    pop         = resp_valid & bus.resp_ready_i;
  end

  always_comb begin
    skid_valid_next = skid_valid_reg;
    skid_addr_next  = skid_addr_reg;
    if (bus.flush_i) begin
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg) begin
      if (bus.addr_ready_i) begin
        skid_valid_next = 1'b0;
      end
    end else if (accept && !bus.addr_ready_i) begin
      skid_valid_next = 1'b1;
      skid_addr_next  = bus.pc_i;
    end
  end

  // Flush turns everything still owed by the cache into discard credit, so the
  // next beats the in-order cache returns are recognised as stale.
  always_comb begin
    in_flight_next = in_flight_reg + CW'(addr_hs) - CW'(data_hs);
    discard_next   = discard_reg;
    if (bus.flush_i) begin
      discard_next = in_flight_reg - CW'(data_hs);
    end else if (drop && (discard_reg != '0)) begin
      discard_next = discard_reg - CW'(1);
    end
  end

  always_comb begin
    occ_next    = occ_reg + CW'(push) - CW'(pop);
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    if (bus.flush_i) begin
      occ_next    = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_valid_reg <= 1'b0;
      skid_addr_reg  <= '0;
      in_flight_reg  <= '0;
      discard_reg    <= '0;
      occ_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      skid_addr_reg  <= skid_addr_next;
      in_flight_reg  <= in_flight_next;
      discard_reg    <= discard_next;
      occ_reg        <= occ_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
    end
  end

  // Storage needs no reset: occ gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.data_i;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.addr_valid_o = addr_valid;
  assign bus.addr_o       = skid_valid_reg ? skid_addr_reg : bus.pc_i;
  assign bus.data_ready_o = data_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_data_o  = fifo_mem[rd_ptr_reg];
  assign bus.read_done_o  = pop;

  assign credit_total = {1'b0, credit_used} + (CW + 2)'(skid_valid_reg);

  credit_invariant: assert property (@(posedge clk_i) disable iff (rst_i)
    credit_total <= (CW + 2)'(MAX_OUT));
endmodule

// File: tb/tb_icache_fetch_tracker.sv
// Bench for icache_fetch_tracker: directed scenarios plus random traffic, checked against
// a queue-based model of skid, cache pipeline (with stale marks) and response FIFO.
module tb_icache_fetch_tracker;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_fetch_tracker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  icache_fetch_tracker #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } ent_t;

  ent_t        cache_q[$];
  logic [31:0] skid_q[$];
  logic [31:0] resp_q[$];

  int errors = 0;
  int checks = 0;

  logic        exp_req_ready, exp_addr_valid, exp_data_ready, exp_resp_valid, exp_read_done;
  logic [31:0] exp_addr, exp_resp_data;

  function automatic logic [31:0] cache_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  task automatic drive(input bit rr, input logic [31:0] pc, input bit ar, input bit dv,
                       input bit rsr, input bit fl);
    bus.read_req_i   = rr;
    bus.pc_i         = pc;
    bus.addr_ready_i = ar;
    bus.data_valid_i = dv;
    bus.resp_ready_i = rsr;
    bus.flush_i      = fl;
  endtask

  // Act as the icache (data for the oldest owed address), then predict outputs.
  task automatic eval();
    if (cache_q.size() != 0) bus.data_i = cache_data(cache_q[0].addr);
    else                     bus.data_i = $urandom;
    #1;
    exp_req_ready  = !bus.flush_i && skid_q.size() == 0 &&
                     (cache_q.size() + resp_q.size() < MAX_OUT);
    exp_addr_valid = !rst && !bus.flush_i &&
                     (skid_q.size() != 0 || (bus.read_req_i && exp_req_ready));
    exp_addr       = (skid_q.size() != 0) ? skid_q[0] : bus.pc_i;
    exp_data_ready = cache_q.size() != 0;
    exp_resp_valid = !bus.flush_i && resp_q.size() != 0;
    exp_resp_data  = (resp_q.size() != 0) ? resp_q[0] : 32'h0;
    exp_read_done  = exp_resp_valid && bus.resp_ready_i;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (rst) begin
      cache_q.delete();
      skid_q.delete();
      resp_q.delete();
    end else begin
      if (exp_read_done) void'(resp_q.pop_front());
      if (bus.data_valid_i && cache_q.size() != 0) begin
        e = cache_q.pop_front();
        if (!e.stale && !bus.flush_i) resp_q.push_back(cache_data(e.addr));
      end
      if (bus.flush_i) begin
        resp_q.delete();
        skid_q.delete();
        foreach (cache_q[i]) cache_q[i].stale = 1'b1;
      end else if (exp_addr_valid && bus.addr_ready_i) begin
        cache_q.push_back('{addr: exp_addr, stale: 1'b0});
        if (skid_q.size() != 0) void'(skid_q.pop_front());
      end else if (bus.read_req_i && exp_req_ready) begin
        skid_q.push_back(bus.pc_i);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      drive(0, 32'h0, 1, 1, 1, 0);
      eval();
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 1, 0, 0, 0);
      eval();
      checks++;
      if (bus.addr_valid_o !== exp_addr_valid) begin
        errors++;
        $display("FAIL reset_prefill_addr_valid: got %b expected %b", bus.addr_valid_o, exp_addr_valid);
      end
      tick();
    end
    drive(1, 32'h80, 1, 1, 1, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.addr_valid_o !== 1'b0 || bus.data_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0 ||
        bus.read_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: got av=%b dr=%b rv=%b rd=%b expected all 0",
               bus.addr_valid_o, bus.data_ready_o, bus.resp_valid_o, bus.read_done_o);
    end
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.addr_o !== 32'h80) begin
      errors++;
      $display("FAIL reset_req_ready_addr: got rr=%b addr=%h expected rr=1 addr=00000080",
               bus.req_ready_o, bus.addr_o);
    end
    tick();
    rst = 1'b0;
    drive(1, 32'h90, 1, 0, 0, 0);
    eval();
    checks++;
    if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== 32'h90) begin
      errors++;
      $display("FAIL reset_first_req: got av=%b addr=%h expected av=1 addr=00000090",
               bus.addr_valid_o, bus.addr_o);
    end
    tick();
    drive(0, 32'h0, 1, 1, 0, 0);
    eval();
    checks++;
    if (bus.data_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_data_ready: got %b expected 1", bus.data_ready_o);
    end
    tick();
    drive(0, 32'h0, 1, 0, 1, 0);
    eval();
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== cache_data(32'h90)) begin
      errors++;
      $display("FAIL reset_first_resp: got v=%b d=%h expected v=1 d=%h",
               bus.resp_valid_o, bus.resp_data_o, cache_data(32'h90));
    end
    tick();
    drain();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 1, 0, 0, 0);
      eval();
      checks++;
      if (bus.req_ready_o !== exp_req_ready || bus.addr_valid_o !== exp_addr_valid ||
          bus.addr_o !== exp_addr) begin
        errors++;
        $display("FAIL stream_issue%0d: got rr=%b av=%b a=%h expected rr=%b av=%b a=%h", i,
                 bus.req_ready_o, bus.addr_valid_o, bus.addr_o, exp_req_ready, exp_addr_valid, exp_addr);
      end
      tick();
    end
    drive(1, 32'h110, 1, 0, 0, 0);
    eval();
    checks++;
    if (bus.req_ready_o !== 1'b0 || bus.addr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_blocked: got rr=%b av=%b expected rr=0 av=0",
               bus.req_ready_o, bus.addr_valid_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 1, 0, 0);
      eval();
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 0, 1, 0);
      eval();
      checks++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== cache_data(32'h100 + 32'(4 * i))) begin
        errors++;
        $display("FAIL stream_order%0d: got v=%b d=%h expected v=1 d=%h", i,
                 bus.resp_valid_o, bus.resp_data_o, cache_data(32'h100 + 32'(4 * i)));
      end
      checks++;
      if (bus.req_ready_o !== exp_req_ready || bus.read_done_o !== exp_read_done) begin
        errors++;
        $display("FAIL stream_reopen%0d: got rr=%b done=%b expected rr=%b done=%b", i,
                 bus.req_ready_o, bus.read_done_o, exp_req_ready, exp_read_done);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_skid();
    drive(1, 32'h200, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      eval();
      checks++;
      if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== 32'h200 || bus.data_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL skid_hold%0d: got av=%b a=%h dr=%b expected av=1 a=00000200 dr=0", i,
                 bus.addr_valid_o, bus.addr_o, bus.data_ready_o);
      end
      tick();
      drive(0, 32'h999, 0, 0, 0, 0);
    end
    drive(0, 32'h444, 1, 0, 0, 0);
    eval();
    checks++;
    if (bus.addr_valid_o !== 1'b1 || bus.addr_o !== 32'h200 || bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL skid_handshake: got av=%b a=%h rr=%b expected av=1 a=00000200 rr=0",
               bus.addr_valid_o, bus.addr_o, bus.req_ready_o);
    end
    tick();
    drive(0, 32'h0, 1, 1, 0, 0);
    eval();
    checks++;
    if (bus.data_ready_o !== 1'b1 || bus.addr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL skid_in_flight: got dr=%b av=%b expected dr=1 av=0",
               bus.data_ready_o, bus.addr_valid_o);
    end
    tick();
    drive(0, 32'h0, 1, 0, 1, 0);
    eval();
    checks++;
    if (bus.resp_data_o !== cache_data(32'h200) || bus.read_done_o !== 1'b1) begin
      errors++;
      $display("FAIL skid_resp: got d=%h done=%b expected d=%h done=1",
               bus.resp_data_o, bus.read_done_o, cache_data(32'h200));
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h280 + 32'(4 * i), 1, 0, 0, 0);
      eval();
      tick();
    end
    drive(0, 32'h0, 1, 1, 0, 0);
    eval();
    tick();
    drive(1, 32'h2f0, 1, 0, 1, 1);
    eval();
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.read_done_o !== 1'b0 || bus.req_ready_o !== 1'b0 ||
        bus.addr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_outputs: got rv=%b done=%b rr=%b av=%b expected all 0",
               bus.resp_valid_o, bus.read_done_o, bus.req_ready_o, bus.addr_valid_o);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h0, 1, 1, 1, 0);
      eval();
      checks++;
      if (bus.data_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_drop%0d: got dr=%b rv=%b expected dr=1 rv=0", i,
                 bus.data_ready_o, bus.resp_valid_o);
      end
      tick();
    end
    drive(1, 32'h300, 1, 0, 1, 0);
    eval();
    checks++;
    if (bus.addr_valid_o !== 1'b1 || bus.resp_valid_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_new_req: got av=%b rv=%b dr=%b expected av=1 rv=0 dr=0",
               bus.addr_valid_o, bus.resp_valid_o, bus.data_ready_o);
    end
    tick();
    drive(0, 32'h0, 1, 1, 1, 0);
    eval();
    tick();
    drive(0, 32'h0, 1, 0, 1, 0);
    eval();
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== cache_data(32'h300)) begin
      errors++;
      $display("FAIL flush_recover_resp: got v=%b d=%h expected v=1 d=%h",
               bus.resp_valid_o, bus.resp_data_o, cache_data(32'h300));
    end
    tick();
    drain();
  endtask

  task automatic test_flush_data();
    drive(1, 32'h380, 1, 0, 0, 0);
    eval();
    tick();
    drive(0, 32'h0, 1, 1, 0, 1);
    eval();
    checks++;
    if (bus.data_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flushdata_ready: got %b expected 1", bus.data_ready_o);
    end
    tick();
    drive(0, 32'h0, 1, 1, 1, 0);
    eval();
    checks++;
    if (bus.data_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flushdata_after: got dr=%b rv=%b expected dr=0 rv=0",
               bus.data_ready_o, bus.resp_valid_o);
    end
    tick();
    drive(1, 32'h384, 1, 0, 0, 0);
    eval();
    tick();
    drive(0, 32'h0, 1, 1, 0, 0);
    eval();
    tick();
    drive(0, 32'h0, 1, 0, 1, 0);
    eval();
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== cache_data(32'h384)) begin
      errors++;
      $display("FAIL flushdata_next: got v=%b d=%h expected v=1 d=%h",
               bus.resp_valid_o, bus.resp_data_o, cache_data(32'h384));
    end
    tick();
    drain();
  endtask

  task automatic test_push_pop_wrap();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 1, 0, 0, 0);
      eval();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 1, 1, 0, 0);
      eval();
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 1, 1, 1, 0);
      eval();
      checks++;
      if (bus.resp_valid_o !== exp_resp_valid || bus.resp_data_o !== exp_resp_data ||
          bus.req_ready_o !== exp_req_ready) begin
        errors++;
        $display("FAIL pushpop%0d: got v=%b d=%h rr=%b expected v=%b d=%h rr=%b", i,
                 bus.resp_valid_o, bus.resp_data_o, bus.req_ready_o,
                 exp_resp_valid, exp_resp_data, exp_req_ready);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)) << 2,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      eval();
      checks++;
      if (bus.req_ready_o !== exp_req_ready || bus.addr_valid_o !== exp_addr_valid ||
          bus.addr_o !== exp_addr || bus.data_ready_o !== exp_data_ready) begin
        errors++;
        $display("FAIL rand_req%0d: got rr=%b av=%b a=%h dr=%b expected rr=%b av=%b a=%h dr=%b", n,
                 bus.req_ready_o, bus.addr_valid_o, bus.addr_o, bus.data_ready_o,
                 exp_req_ready, exp_addr_valid, exp_addr, exp_data_ready);
      end
      checks++;
      if (bus.resp_valid_o !== exp_resp_valid || bus.read_done_o !== exp_read_done ||
          (exp_resp_valid && bus.resp_data_o !== exp_resp_data)) begin
        errors++;
        $display("FAIL rand_resp%0d: got v=%b done=%b d=%h expected v=%b done=%b d=%h", n,
                 bus.resp_valid_o, bus.read_done_o, bus.resp_data_o,
                 exp_resp_valid, exp_read_done, exp_resp_data);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    drive(0, 32'h0, 0, 0, 0, 0);
    bus.data_i = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_flush_data();
    test_push_pop_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
